// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmitter.
//   - FSM state encoding (IDLE/START/DATA/PARITY/STOP)
//   - parity-type and stop-bit constants
//   - latched per-frame configuration payload
//   - small helpers for the parity bit and the last-stop-bit test
package uart_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_START  = 3'd1;
  localparam logic [STATE_W-1:0] ST_DATA   = 3'd2;
  localparam logic [STATE_W-1:0] ST_PARITY = 3'd3;
  localparam logic [STATE_W-1:0] ST_STOP   = 3'd4;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Stop-bit selector values; STOP_TWO also marks the second stop bit slot.
  localparam logic STOP_ONE = 1'b0;
  localparam logic STOP_TWO = 1'b1;

  // Frame configuration captured at acceptance.
  typedef struct packed {
    logic par_en;
    logic par_typ;
    logic stop2;
  } tx_cfg_t;

  // Parity bit from the XOR-reduction of the data word.
  function automatic logic parity_bit(input logic par_typ, input logic data_xor);
    logic p;
    p = data_xor;
    case (par_typ)
      PAR_EVEN: p = data_xor;
      PAR_ODD:  p = ~data_xor;
    endcase
    return p;
  endfunction

  // True when the current stop bit slot is the final one of the frame.
  function automatic logic stop_is_last(input logic stop2, input logic stop_cnt);
    logic last;
    last = 1'b1;
    case (stop2)
      STOP_ONE: last = 1'b1;
      STOP_TWO: last = (stop_cnt == STOP_TWO);
    endcase
    return last;
  endfunction

endpackage

// File: rtl/uart_tx_baud_gen.sv
// uart_tx_baud_gen: bit-period timing for uart_tx_frame.
// Optional macro UART_TX_PRESCALE_EN:
//   defined   - prescale counter; each bit lasts PRESCALE cycles (0 treated as 1),
//               PRESCALE latched on load, counter idles at 0 when not running.
//   undefined - every cycle is a bit boundary; bit_end tied high.
// Ports (macro defined):
//   clk, rst_n      clock, async active-low reset
//   load            frame accepted this cycle (latch prescale, restart period)
//   run             FSM will be outside IDLE next cycle
//   prescale        requested bit period in clk cycles
//   bit_end         registered: current cycle is the last of a bit period
//   bit_end_nxt_c   combinational: next cycle will be the last of a bit period
// Ports (macro undefined): bit_end, bit_end_nxt_c only (both constant 1).
`ifdef UART_TX_PRESCALE_EN
module uart_tx_baud_gen #(
  parameter int unsigned PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic                      run,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      bit_end,
  output logic                      bit_end_nxt_c
);

  logic [PRESCALE_WIDTH-1:0] period_q, period_d, period_in;
  logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;

  // Down-counter: reloads on load or at every bit boundary while running.
  always_comb begin
    period_in = (prescale == '0) ? PRESCALE_WIDTH'(1) : prescale;
    period_d  = period_q;
    cnt_d     = '0;
    if (load) begin
      period_d = period_in;
      cnt_d    = period_in - PRESCALE_WIDTH'(1);
    end else if (run) begin
      cnt_d = (cnt_q == '0) ? (period_q - PRESCALE_WIDTH'(1)) : (cnt_q - PRESCALE_WIDTH'(1));
    end
  end

  assign bit_end_nxt_c = run & (cnt_d == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_q <= '0;
      cnt_q    <= '0;
      bit_end  <= 1'b0;
    end else begin
      period_q <= period_d;
      cnt_q    <= cnt_d;
      bit_end  <= bit_end_nxt_c;
    end
  end

endmodule
`else
module uart_tx_baud_gen (
  output logic bit_end,
  output logic bit_end_nxt_c
);

  // One clock per bit: every cycle closes a bit period.
  assign bit_end       = 1'b1;
  assign bit_end_nxt_c = 1'b1;

endmodule
`endif

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter with ready/valid input.
// Frame: start bit, DATA_WIDTH data bits LSB first, optional parity, 1 or 2 stop bits.
// Back-to-back frames are accepted in the final cycle of the final stop bit.
// Optional macro UART_TX_PRESCALE_EN adds PRESCALE (bit period in CLK cycles).
// Ports:
//   CLK         TX clock
//   RST         asynchronous active-low reset
//   P_DATA      parallel word to send
//   DATA_VALID  P_DATA and config inputs valid
//   PAR_EN      append parity bit
//   PAR_TYP     0 = even, 1 = odd parity
//   STOP2       0 = one stop bit, 1 = two stop bits
//   PRESCALE    bit period (macro only; 0 treated as 1)
//   READY       word accepted this cycle if DATA_VALID (registered)
//   TX_OUT      serial line, idles high (registered)
//   Busy        frame in progress (registered)
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
`ifdef UART_TX_PRESCALE_EN
  , parameter int unsigned PRESCALE_WIDTH = 6
`endif
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      DATA_VALID,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic                      STOP2,
`ifdef UART_TX_PRESCALE_EN
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
`endif
  output logic                      READY,
  output logic                      TX_OUT,
  output logic                      Busy
);

  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  logic [STATE_W-1:0]    state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  tx_cfg_t               cfg_q, cfg_d, cfg_in;
  logic                  stop_cnt_q, stop_cnt_d;
  logic                  tx_d, busy_d, ready_d;
  logic                  accept, load;
  logic                  bit_end, bit_end_nxt_c;

  assign accept = DATA_VALID & READY;
  assign cfg_in = '{par_en: PAR_EN, par_typ: PAR_TYP, stop2: STOP2};

`ifdef UART_TX_PRESCALE_EN
  uart_tx_baud_gen #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_baud (
    .clk           (CLK),
    .rst_n         (RST),
    .load          (load),
    .run           (busy_d),
    .prescale      (PRESCALE),
    .bit_end       (bit_end),
    .bit_end_nxt_c (bit_end_nxt_c)
  );
`else
  uart_tx_baud_gen u_baud (
    .bit_end       (bit_end),
    .bit_end_nxt_c (bit_end_nxt_c)
  );
`endif

  // Next-state, latch and next-output logic.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    data_d     = data_q;
    cfg_d      = cfg_q;
    stop_cnt_d = stop_cnt_q;
    load       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) load = 1'b1;
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (idx_q == LAST_IDX) begin
            state_d    = cfg_q.par_en ? ST_PARITY : ST_STOP;
            stop_cnt_d = 1'b0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d    = ST_STOP;
          stop_cnt_d = 1'b0;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (stop_is_last(cfg_q.stop2, stop_cnt_q)) begin
            if (accept) load = 1'b1;
            else        state_d = ST_IDLE;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Acceptance restarts a frame from either IDLE or the last stop cycle.
    if (load) begin
      state_d    = ST_START;
      data_d     = P_DATA;
      cfg_d      = cfg_in;
      idx_d      = '0;
      stop_cnt_d = 1'b0;
    end

    tx_d = 1'b1;
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = data_q[idx_d];
      ST_PARITY: tx_d = parity_bit(cfg_q.par_typ, ^data_q);
      default:   tx_d = 1'b1;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Kept apart from the main block: bit_end_nxt_c depends on load/busy_d.
  assign ready_d = (state_d == ST_IDLE) |
                   ((state_d == ST_STOP) & stop_is_last(cfg_d.stop2, stop_cnt_d) & bit_end_nxt_c);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      data_q     <= '0;
      cfg_q      <= '0;
      stop_cnt_q <= 1'b0;
      TX_OUT     <= 1'b1;
      Busy       <= 1'b0;
      READY      <= 1'b1;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      cfg_q      <= cfg_d;
      stop_cnt_q <= stop_cnt_d;
      TX_OUT     <= tx_d;
      Busy       <= busy_d;
      READY      <= ready_d;
    end
  end

endmodule
